rf_write_arbiter: RTL and testbench
===================================

Name: rf_write_arbiter

Overview:
Sequencer and write-port arbiter for the 8x16 register file.
- After reset, it writes the register file's initial contents (reg i = i+1), because the register file has no reset of its own.
- It then shares the single write port between two requesters: A (ALU writeback) and B (memory/load writeback). Arbitration is round-robin with a valid/ready handshake.
- The write port is driven from a registered output stage, so each accepted write reaches the register file exactly one cycle after acceptance.

Parameters:
DATA_W, 16, width of register data
ADDR_W, 3, width of register address
NUM_REGS, 8, number of registers initialised after reset (must equal 2**ADDR_W)

Ports:
clk  input  1  system clock; all state updates on rising edge
rst  input  1  reset, synchronous, active-low (0 = reset)
a_valid  input  1  requester A has a write pending
a_dest  input  ADDR_W  requester A destination register
a_data  input  DATA_W  requester A write data
a_ready  output  1  requester A write accepted this cycle
b_valid  input  1  requester B has a write pending
b_dest  input  ADDR_W  requester B destination register
b_data  input  DATA_W  requester B write data
b_ready  output  1  requester B write accepted this cycle
reg_write_en  output  1  write enable to register file (registered)
reg_write_dest  output  ADDR_W  write address to register file (registered)
reg_write_data  output  DATA_W  write data to register file (registered)
init_done  output  1  high once initialisation writes are complete (registered)

Behaviour:
- Reset (rst=0 at a rising clk edge):
  - state=INIT, init_cnt=0, rr_ptr=0 (A favoured).
  - reg_write_en=0, reg_write_dest=0, reg_write_data=0, init_done=0.
  - a_ready and b_ready are forced to 0 while rst=0.
- Reset asserted mid-operation: any in-flight write is dropped (reg_write_en=0 next cycle) and the full INIT sequence restarts.
- State INIT:
  - Each cycle registers reg_write_en=1, reg_write_dest=init_cnt, reg_write_data=init_cnt+1 (zero-extended to DATA_W), then init_cnt++.
  - When init_cnt reaches NUM_REGS-1, that write is issued and state moves to RUN.
  - init_done=1 from the same edge as that last INIT write.
  - a_ready=b_ready=0 throughout INIT.
- INIT timing: the first init write appears one edge after reset deasserts. Writes for regs 0..7 occupy 8 consecutive cycles, and init_done is high on the cycle reg 7 is presented.
- State RUN, grant (combinational from valids, rr_ptr and state):
  - only a_valid -> a_ready=1
  - only b_valid -> b_ready=1
  - both valid -> grant goes to rr_ptr (0=A, 1=B)
  - neither valid -> no grant
  - a_ready and b_ready are never both 1.
- rr_ptr updates only on a contested grant (both valid); it then points to the loser. An uncontested grant leaves rr_ptr unchanged.
- Transfer = valid&&ready. On transfer, the next edge registers reg_write_en=1, reg_write_dest=granted dest, reg_write_data=granted data.
  - Latency from acceptance to write: 1 cycle.
  - Throughput: 1 write per cycle.
- No transfer: the next edge registers reg_write_en=0; reg_write_dest and reg_write_data hold their previous values.
- Same destination from A and B in one cycle: only the granted write proceeds. The loser is written on a later cycle, so the loser's data is the final register value.
- Requester obligations: hold valid/dest/data stable until ready; the arbiter does not check this. Valid may rise in any cycle, including during INIT (no grant until RUN).
- RUN persists until reset; there is no other exit.

Test Plan:
- Reset held 3 cycles, then released with a_valid=b_valid=0 -> 8 consecutive writes (dest 0..7, data 0x0001..0x0008); init_done=1 on the dest-7 cycle; then reg_write_en=0; readies stay 0 during INIT.
- After init, a_valid=1, a_dest=3, a_data=0xBEEF for one cycle -> a_ready=1 that cycle; next cycle reg_write_en=1, dest=3, data=0xBEEF; the following cycle reg_write_en=0 with dest/data held.
- Both valid continuously (A: dest 1, 0x1111; B: dest 2, 0x2222; each requester drops valid after acceptance then re-raises) -> grants alternate A, B, A, B starting with A; writes appear one cycle after each grant.
- Same-dest contest (A: dest 5, 0xAAAA; B: dest 5, 0x5555) with rr_ptr=1 -> B granted first, A second; final write sequence 0x5555 then 0xAAAA to reg 5.
- a_valid=1 raised during INIT cycle 4 -> a_ready stays 0 until the first RUN cycle, then 1; the write follows one cycle later.
- rst driven 0 for 1 cycle while grants are streaming -> next cycle reg_write_en=0 with readies low; the INIT sequence replays fully (dest 0..7, data 1..8) before any grant.

Source files
------------

// File: rtl/rf_write_arbiter_if.sv
// Write-port bundle between the two writeback requesters, the arbiter and
// the 8x16 register file. The arbiter uses the slave view. The requesters
// and the register file together form the master view.
interface rf_write_arbiter_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 3
);

  // Requester A (ALU writeback)
  logic              a_valid;
  logic [ADDR_W-1:0] a_dest;
  logic [DATA_W-1:0] a_data;
  logic              a_ready;

  // Requester B (memory/load writeback)
  logic              b_valid;
  logic [ADDR_W-1:0] b_dest;
  logic [DATA_W-1:0] b_data;
  logic              b_ready;

  // Registered write port into the register file
  logic              reg_write_en;
  logic [ADDR_W-1:0] reg_write_dest;
  logic [DATA_W-1:0] reg_write_data;
  logic              init_done;

  modport slave (
    input  a_valid, a_dest, a_data,
    input  b_valid, b_dest, b_data,
    output a_ready, b_ready,
    output reg_write_en, reg_write_dest, reg_write_data, init_done
  );

  modport master (
    output a_valid, a_dest, a_data,
    output b_valid, b_dest, b_data,
    input  a_ready, b_ready,
    input  reg_write_en, reg_write_dest, reg_write_data, init_done
  );

endinterface

// File: rtl/rf_write_arbiter.sv
// Sequencer and write-port arbiter for the 8x16 register file.
// After reset it loads reg i with i+1, one register per cycle. The register
// file has no reset of its own, so this load supplies its initial contents.
// After the load it shares the single write port between the ALU (A) and
// load (B) writebacks. The arbitration is round-robin.
// Every accepted write is registered, so it reaches the register file one
// cycle after the handshake.
module rf_write_arbiter #(
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 3,
  parameter int NUM_REGS = 8
) (
  input logic               clk,
  input logic               rst,
  rf_write_arbiter_if.slave bus
);

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] init_cnt_q, init_cnt_d;
  logic              rr_ptr_q, rr_ptr_d;
  logic              wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] wr_dest_q, wr_dest_d;
  logic [DATA_W-1:0] wr_data_q, wr_data_d;
  logic              init_done_q, init_done_d;

  logic              a_grant;
  logic              b_grant;
  logic              contested;
  logic              last_init;

  // Grant logic. Grants are issued only in RUN and never while reset is held.
  // When both requesters are valid, rr_ptr picks the winner (0 = A, 1 = B).
  always_comb begin
    contested = bus.a_valid && bus.b_valid;
    a_grant   = 1'b0;
    b_grant   = 1'b0;
    if (rst && (state_q == RUN)) begin
      a_grant = bus.a_valid && (!bus.b_valid || !rr_ptr_q);
      b_grant = bus.b_valid && (!bus.a_valid ||  rr_ptr_q);
    end
  end

  assign bus.a_ready = a_grant;
  assign bus.b_ready = b_grant;

  // Next-state and next-output logic.
  // By default no write is issued, the address and data hold their values,
  // and the other state is kept as it is.
  always_comb begin
    state_d     = state_q;
    init_cnt_d  = init_cnt_q;
    rr_ptr_d    = rr_ptr_q;
    wr_en_d     = 1'b0;
    wr_dest_d   = wr_dest_q;
    wr_data_d   = wr_data_q;
    init_done_d = init_done_q;
    last_init   = (init_cnt_q == ADDR_W'(NUM_REGS - 1));

    case (state_q)
      INIT: begin
        wr_en_d    = 1'b1;
        wr_dest_d  = init_cnt_q;
        wr_data_d  = DATA_W'(init_cnt_q) + DATA_W'(1);
        init_cnt_d = init_cnt_q + ADDR_W'(1);
        if (last_init) begin
          state_d     = RUN;
          init_done_d = 1'b1;
        end
      end
      RUN: begin
        if (a_grant) begin
          wr_en_d   = 1'b1;
          wr_dest_d = bus.a_dest;
          wr_data_d = bus.a_data;
        end else if (b_grant) begin
          wr_en_d   = 1'b1;
          wr_dest_d = bus.b_dest;
          wr_data_d = bus.b_data;
        end
        // After a contested grant the pointer moves to the loser. The winner
        // is always the side rr_ptr named, so the pointer simply flips.
        if (contested) begin
          rr_ptr_d = ~rr_ptr_q;
        end
      end
      default: begin
        state_d = INIT;
      end
    endcase
  end

  // State and output registers. A synchronous active-low reset drops any
  // in-flight write and restarts the initialisation sequence.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= INIT;
      init_cnt_q  <= '0;
      rr_ptr_q    <= 1'b0;
      wr_en_q     <= 1'b0;
      wr_dest_q   <= '0;
      wr_data_q   <= '0;
      init_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      init_cnt_q  <= init_cnt_d;
      rr_ptr_q    <= rr_ptr_d;
      wr_en_q     <= wr_en_d;
      wr_dest_q   <= wr_dest_d;
      wr_data_q   <= wr_data_d;
      init_done_q <= init_done_d;
    end
  end

  assign bus.reg_write_en   = wr_en_q;
  assign bus.reg_write_dest = wr_dest_q;
  assign bus.reg_write_data = wr_data_q;
  assign bus.init_done      = init_done_q;

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Directed testbench for rf_write_arbiter. Inputs are driven 1 ns after
// each rising edge. Outputs are sampled then as well, or 1 ns later when
// the readies depend on inputs that were just changed.
module tb_rf_write_arbiter;

  localparam int DATA_W   = 16;
  localparam int ADDR_W   = 3;
  localparam int NUM_REGS = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   tests_run    = 0;
  int   tests_failed = 0;

  rf_write_arbiter_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  rf_write_arbiter #(
    .DATA_W  (DATA_W),
    .ADDR_W  (ADDR_W),
    .NUM_REGS(NUM_REGS)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // 10 ns clock
  always #5 clk = ~clk;

  // Advance to just after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive both requester interfaces
  task automatic applyStimulus(input logic av, input logic [ADDR_W-1:0] ad,
                               input logic [DATA_W-1:0] adat,
                               input logic bv, input logic [ADDR_W-1:0] bd,
                               input logic [DATA_W-1:0] bdat);
    bus.a_valid = av;
    bus.a_dest  = ad;
    bus.a_data  = adat;
    bus.b_valid = bv;
    bus.b_dest  = bd;
    bus.b_data  = bdat;
  endtask

  // Compare the registered write port and init_done with the expected values
  task automatic checkOutput(input string tag, input logic en,
                             input logic [ADDR_W-1:0] dest,
                             input logic [DATA_W-1:0] data,
                             input logic done);
    tests_run++;
    assert (bus.reg_write_en === en) else begin
      tests_failed++;
      $error("[TB] FAIL %s reg_write_en: observed %0b expected %0b", tag, bus.reg_write_en, en);
    end
    tests_run++;
    assert (bus.reg_write_dest === dest) else begin
      tests_failed++;
      $error("[TB] FAIL %s reg_write_dest: observed %0d expected %0d", tag, bus.reg_write_dest, dest);
    end
    tests_run++;
    assert (bus.reg_write_data === data) else begin
      tests_failed++;
      $error("[TB] FAIL %s reg_write_data: observed %h expected %h", tag, bus.reg_write_data, data);
    end
    tests_run++;
    assert (bus.init_done === done) else begin
      tests_failed++;
      $error("[TB] FAIL %s init_done: observed %0b expected %0b", tag, bus.init_done, done);
    end
  endtask

  // Compare the combinational readies with the expected values
  task automatic checkReady(input string tag, input logic ea, input logic eb);
    tests_run++;
    assert (bus.a_ready === ea) else begin
      tests_failed++;
      $error("[TB] FAIL %s a_ready: observed %0b expected %0b", tag, bus.a_ready, ea);
    end
    tests_run++;
    assert (bus.b_ready === eb) else begin
      tests_failed++;
      $error("[TB] FAIL %s b_ready: observed %0b expected %0b", tag, bus.b_ready, eb);
    end
  endtask

  initial begin
    // Reset held for 3 cycles with both requesters idle
    applyStimulus(1'b0, 3'd0, 16'h0000, 1'b0, 3'd0, 16'h0000);
    rst = 1'b0;
    repeat (3) tick();
    checkOutput("reset", 1'b0, 3'd0, 16'h0000, 1'b0);
    checkReady("reset", 1'b0, 1'b0);

    // Release reset: 8 init writes (reg i <- i+1), init_done on the last one
    rst = 1'b1;
    #1;
    checkReady("init_start", 1'b0, 1'b0);
    for (int i = 0; i < NUM_REGS; i++) begin
      tick();
      checkOutput($sformatf("init%0d", i), 1'b1, ADDR_W'(i), DATA_W'(i + 1), (i == NUM_REGS - 1));
    end
    tick();
    checkOutput("post_init_idle", 1'b0, 3'd7, 16'h0008, 1'b1);

    // Single uncontested write from A
    applyStimulus(1'b1, 3'd3, 16'hBEEF, 1'b0, 3'd0, 16'h0000);
    #1;
    checkReady("single_a", 1'b1, 1'b0);
    tick();
    applyStimulus(1'b0, 3'd3, 16'hBEEF, 1'b0, 3'd0, 16'h0000);
    checkOutput("single_a_wr", 1'b1, 3'd3, 16'hBEEF, 1'b1);
    tick();
    checkOutput("single_a_hold", 1'b0, 3'd3, 16'hBEEF, 1'b1);

    // Both requesters always valid: grants alternate A, B, A, B
    applyStimulus(1'b1, 3'd1, 16'h1111, 1'b1, 3'd2, 16'h2222);
    for (int k = 0; k < 4; k++) begin
      #1;
      checkReady($sformatf("alt%0d", k), (k % 2 == 0), (k % 2 == 1));
      tick();
      if (k % 2 == 0)
        checkOutput($sformatf("alt%0d_wr", k), 1'b1, 3'd1, 16'h1111, 1'b1);
      else
        checkOutput($sformatf("alt%0d_wr", k), 1'b1, 3'd2, 16'h2222, 1'b1);
    end
    applyStimulus(1'b0, 3'd0, 16'h0000, 1'b0, 3'd0, 16'h0000);

    // A wins a contest (pointer -> B), then B is served alone (pointer kept)
    applyStimulus(1'b1, 3'd6, 16'h6666, 1'b1, 3'd4, 16'h4444);
    #1;
    checkReady("setup_contest", 1'b1, 1'b0);
    tick();
    applyStimulus(1'b0, 3'd6, 16'h6666, 1'b1, 3'd4, 16'h4444);
    checkOutput("setup_a_wr", 1'b1, 3'd6, 16'h6666, 1'b1);
    #1;
    checkReady("setup_b_alone", 1'b0, 1'b1);
    tick();

    // Same destination contest with pointer at B: B first, then A
    applyStimulus(1'b1, 3'd5, 16'hAAAA, 1'b1, 3'd5, 16'h5555);
    checkOutput("setup_b_wr", 1'b1, 3'd4, 16'h4444, 1'b1);
    #1;
    checkReady("same_dest_b", 1'b0, 1'b1);
    tick();
    applyStimulus(1'b1, 3'd5, 16'hAAAA, 1'b0, 3'd5, 16'h5555);
    checkOutput("same_dest_b_wr", 1'b1, 3'd5, 16'h5555, 1'b1);
    #1;
    checkReady("same_dest_a", 1'b1, 1'b0);
    tick();
    applyStimulus(1'b0, 3'd0, 16'h0000, 1'b0, 3'd0, 16'h0000);
    checkOutput("same_dest_a_wr", 1'b1, 3'd5, 16'hAAAA, 1'b1);
    tick();
    checkOutput("same_dest_hold", 1'b0, 3'd5, 16'hAAAA, 1'b1);

    // Streaming A writes, then reset pulsed for one cycle
    applyStimulus(1'b1, 3'd2, 16'h1234, 1'b0, 3'd0, 16'h0000);
    #1;
    checkReady("stream0", 1'b1, 1'b0);
    tick();
    checkOutput("stream0_wr", 1'b1, 3'd2, 16'h1234, 1'b1);
    checkReady("stream1", 1'b1, 1'b0);
    rst = 1'b0;
    #1;
    checkReady("rst_forced", 1'b0, 1'b0);
    tick();
    rst = 1'b1;
    applyStimulus(1'b0, 3'd0, 16'h0000, 1'b0, 3'd0, 16'h0000);
    checkOutput("rst_mid", 1'b0, 3'd0, 16'h0000, 1'b0);

    // INIT replays fully. A is raised mid-INIT but is not granted until RUN.
    for (int i = 0; i < NUM_REGS; i++) begin
      tick();
      checkOutput($sformatf("replay%0d", i), 1'b1, ADDR_W'(i), DATA_W'(i + 1), (i == NUM_REGS - 1));
      if (i == 3) applyStimulus(1'b1, 3'd2, 16'h1234, 1'b0, 3'd0, 16'h0000);
      #1;
      checkReady($sformatf("replay%0d_rdy", i), (i == NUM_REGS - 1), 1'b0);
    end
    tick();
    applyStimulus(1'b0, 3'd0, 16'h0000, 1'b0, 3'd0, 16'h0000);
    checkOutput("late_a_wr", 1'b1, 3'd2, 16'h1234, 1'b1);
    tick();
    checkOutput("late_a_hold", 1'b0, 3'd2, 16'h1234, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
